// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: default width, op codes, FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 11;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: one partial-product step per enabled edge.
// o_prod_next is the product including the current step, so the caller can
// register the final value on the same edge that o_done is high.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int STEPS = WIDTH
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_prod_next,
    output logic                 o_done
);

    localparam int CW = $clog2(STEPS + 1);

    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;

    assign o_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign o_done      = i_step && (r_cnt == CW'(STEPS - 1));

    // Load operands on start, then add-and-shift once per step.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
        end else if (i_step) begin
            r_cnt    <= r_cnt + 1'b1;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= o_prod_next;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU: single-cycle logic/arith ops, iterative MUL.
// Results and flags are registered and held until the next completion;
// alu_wr pulses for one cycle per completed operation.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic              clock,
    input  logic              alu_reset_n,
    input  logic              alu_start,
    input  logic [2:0]        alu_op,
    input  logic [WIDTH-1:0]  alu_a,
    input  logic [WIDTH-1:0]  alu_b,
    output logic [WIDTH-1:0]  alu_out,
    output logic              alu_wr,
    output logic              alu_busy,
    output logic              alu_z,
    output logic              alu_n,
    output logic              alu_c
);

    alu_state_t          r_state;
    logic [WIDTH-1:0]    r_out;
    logic                r_wr;
    logic                r_z;
    logic                r_n;
    logic                r_c;

    logic                w_accept;
    logic                w_is_mul;
    logic [WIDTH:0]      w_res;       // {carry, result} for single-cycle ops
    logic [2*WIDTH-1:0]  w_prod;
    logic                w_mul_done;

    assign w_accept = (r_state == ST_IDLE) && alu_start;
    assign w_is_mul = (alu_op_t'(alu_op) == OP_MUL);

    // Single-cycle result with its carry/borrow/shift-out bit.
    always_comb begin
        w_res = '0;
        case (alu_op_t'(alu_op))
            OP_ADD:  w_res = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  w_res = {(alu_a < alu_b), alu_a - alu_b};
            OP_AND:  w_res = {1'b0, alu_a & alu_b};
            OP_OR:   w_res = {1'b0, alu_a | alu_b};
            OP_XOR:  w_res = {1'b0, alu_a ^ alu_b};
            OP_NOT:  w_res = {1'b0, ~alu_a};
            OP_SHL:  w_res = {alu_a, 1'b0};
            default: w_res = '0;
        endcase
    end

    mul_shift_add #(
        .WIDTH (WIDTH),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clock       (clock),
        .rst_n       (alu_reset_n),
        .i_load      (w_accept && w_is_mul),
        .i_step      (r_state == ST_RUN),
        .i_a         (alu_a),
        .i_b         (alu_b),
        .o_prod_next (w_prod),
        .o_done      (w_mul_done)
    );

    // Control FSM plus result/flag registers; start is only looked at in IDLE.
    always_ff @(posedge clock or negedge alu_reset_n) begin
        if (!alu_reset_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_wr    <= 1'b0;
            r_z     <= 1'b1;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (alu_start) begin
                        if (w_is_mul) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                            r_wr    <= 1'b1;
                            r_out   <= w_res[WIDTH-1:0];
                            r_c     <= w_res[WIDTH];
                            r_z     <= (w_res[WIDTH-1:0] == '0);
                            r_n     <= w_res[WIDTH-1];
                        end
                    end
                end
                ST_RUN: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                        r_wr    <= 1'b1;
                        r_out   <= w_prod[WIDTH-1:0];
                        r_c     <= |w_prod[2*WIDTH-1:WIDTH];
                        r_z     <= (w_prod[WIDTH-1:0] == '0);
                        r_n     <= w_prod[WIDTH-1];
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_out  = r_out;
    assign alu_wr   = r_wr;
    assign alu_busy = (r_state != ST_IDLE);
    assign alu_z    = r_z;
    assign alu_n    = r_n;
    assign alu_c    = r_c;

    // Used only by the start-acceptance path; keeps the accept term observable.
    logic w_unused;
    assign w_unused = w_accept;

endmodule
